mm_entry_store: RTL and testbench
=================================

// Module: mm_entry_store
// PURPOSE
//  Matching-memory entry array on the far side of the match/allocate/access controller.
//  Holds waiting packets with key, data and valid bit; compares each incoming key against all entries.
//  Drives FIRE/VALID/MF to the controller and consumes its registered WR_E/DEL/ADDR to write or fire+delete.
//  Emits matched operand pairs, or unmatched bypass packets, on a valid/ack output port.
// PARAMETERS
//  ENTRIES  64  number of entries (matches controller FIRE/VALID/EN width)
//  ADDR_W   6   entry address width, clog2(ENTRIES)
//  KEY_W    16  match key width (destination + generation tag)
//  DATA_W   16  operand data width
// PORTS
//  CP         in   1        clock, all state on rising edge
//  MR         in   1        reset, asynchronous, active-high
//  IN_V       in   1        incoming packet valid
//  IN_RDY     out  1        store can accept; transfer = IN_V & IN_RDY
//  IN_MF      in   1        1: packet must be matched; 0: bypass
//  IN_KEY     in   KEY_W    match key
//  IN_DATA    in   DATA_W   operand
//  FIRE       out  ENTRIES  per-entry hit: VALID[i] & KEY[i]==IN_KEY & IN_V & IN_MF
//  VALID      out  ENTRIES  entry occupied bits
//  MF         out  1        IN_V & IN_RDY & IN_MF, to controller
//  WR_E       in   1        controller write strobe (registered)
//  DEL        in   1        controller delete strobe (registered)
//  ADDR       in   ADDR_W   controller write/read address (registered)
//  OUT_V      out  1        output packet valid
//  OUT_ACK    in   1        output consumed; transfer = OUT_V & OUT_ACK
//  OUT_PAIR   out  1        1: matched pair; 0: bypass
//  OUT_KEY    out  KEY_W    packet key
//  OUT_DATA_S out  DATA_W   stored partner operand (0 if bypass)
//  OUT_DATA_I out  DATA_W   incoming operand
//  OVF        out  1        sticky: WR_E seen to an already-valid entry
// BEHAVIOUR
//  - Reset: VALID=0, S2_V=0, OUT_V=0, OUT_PAIR=0, OUT_KEY/OUT_DATA_*=0, OVF=0. Key/data arrays not cleared.
//  - IN_RDY = ~S2_V & ~(OUT_V & ~OUT_ACK) & (~IN_MF | ~&VALID | |FIRE).
//    When full, an unmatched MF packet waits; hits and bypasses still pass.
//  - Cycle T, transfer: S2 captures {KEY,DATA,MF,HIT=|FIRE}; controller captures ADDR/WR_E/DEL same edge.
//  - Cycle T+1 (S2_V=1), resolved at end of T+1:
//    S2_MF & ~S2_HIT & WR_E: entry[ADDR] <= {KEY,DATA}, VALID[ADDR] <= 1; no output.
//    S2_MF & S2_HIT & DEL: OUT <= {PAIR=1, KEY, DATA_S=entry[ADDR].data, DATA_I}; VALID[ADDR] <= 0.
//    ~S2_MF: OUT <= {PAIR=0, KEY, DATA_S=0, DATA_I}; controller strobes ignored.
//  - Latency: input transfer at T -> OUT_V=1 from T+2 (pair or bypass). Write visible to FIRE from T+2.
//  - Throughput: one packet per 2 cycles. S2 never stalls; IN_RDY rule guarantees a free output slot at T+1.
//  - DEL with S2_V=0 or S2_HIT=0 (idle, reset default DEL=1) is ignored; no entry is cleared.
//  - WR_E with S2_V=0 is ignored.
//  - WR_E to an entry with VALID=1: data overwritten, OVF set (error; must not occur).
//  - OUT_V holds with OUT_* stable until OUT_ACK; clears on ack. No new load in the ack cycle.
//  - Duplicate keys: FIRE may be multi-hot; controller picks the lowest index; only that entry is deleted.
//  - MR mid-operation: S2 and pending output dropped; all entries invalidated immediately.
// TESTING
//  1. Reset: MR pulse -> VALID=0, OUT_V=0, IN_RDY=1, OVF=0; idle DEL=1 clears nothing.
//  2. Write then match: {MF=1,KEY=0x0012,DATA=0x0005} -> VALID[0]=1, no OUT_V.
//     Then {MF=1,KEY=0x0012,DATA=0x0007} -> FIRE[0]=1; 2 cycles later OUT_V=1, PAIR=1, DATA_S=5, DATA_I=7; VALID[0]=0.
//  3. Bypass: {MF=0,KEY=0x0003,DATA=0x00AA} -> OUT_V at T+2, PAIR=0, DATA_S=0, DATA_I=0xAA; VALID unchanged.
//  4. Full: fill 64 distinct keys -> VALID all 1.
//     New-key MF packet -> IN_RDY=0 held. Key of entry 37 -> accepted, VALID[37]=0, OUT pair; next new key then writes entry 37.
//  5. Backpressure: OUT_ACK=0 for 5 cycles after a bypass -> OUT_* stable, IN_RDY=0; ack -> OUT_V=0, IN_RDY=1 next cycle.
//  6. MR asserted in the cycle S2_V=1 on a hit -> no OUT_V, VALID=0 at once.

Source files
------------

// File: rtl/mm_entry_store.sv
// rtl/mm_entry_store.sv - matching-memory entry array with match compare, write/fire-delete and output port
//
// Holds waiting operand packets as {key, data, valid} entries. Every incoming
// key is compared against all entries at once (FIRE). An external controller
// registers FIRE/VALID/MF on the transfer edge and returns WR_E/DEL/ADDR during
// the following cycle, while the packet sits in the single S2 stage.
// S2 then either writes the packet into a free entry, or pairs it with the
// stored partner and deletes that entry, or passes a bypass packet through.
//
// Ports:
//   CP, MR           clock (rising edge) / asynchronous active-high reset
//   IN_V, IN_RDY     input handshake, transfer = IN_V & IN_RDY
//   IN_MF            1: packet must be matched, 0: bypass
//   IN_KEY, IN_DATA  incoming key and operand
//   FIRE             per-entry hit vector for the current input
//   VALID            entry occupied bits
//   MF               accepted match-required packet, to controller
//   WR_E, DEL, ADDR  registered controller strobes and entry address
//   OUT_V, OUT_ACK   output handshake, transfer = OUT_V & OUT_ACK
//   OUT_PAIR         1: matched pair, 0: bypass
//   OUT_KEY          packet key
//   OUT_DATA_S       stored partner operand (0 for bypass)
//   OUT_DATA_I       incoming operand
//   OVF              sticky: write to an already-valid entry
module mm_entry_store #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 6,
  parameter int KEY_W   = 16,
  parameter int DATA_W  = 16
) (
  input  logic               CP,
  input  logic               MR,
  input  logic               IN_V,
  output logic               IN_RDY,
  input  logic               IN_MF,
  input  logic [KEY_W-1:0]   IN_KEY,
  input  logic [DATA_W-1:0]  IN_DATA,
  output logic [ENTRIES-1:0] FIRE,
  output logic [ENTRIES-1:0] VALID,
  output logic               MF,
  input  logic               WR_E,
  input  logic               DEL,
  input  logic [ADDR_W-1:0]  ADDR,
  output logic               OUT_V,
  input  logic               OUT_ACK,
  output logic               OUT_PAIR,
  output logic [KEY_W-1:0]   OUT_KEY,
  output logic [DATA_W-1:0]  OUT_DATA_S,
  output logic [DATA_W-1:0]  OUT_DATA_I,
  output logic               OVF
);

  // Entry storage. Key/data are never reset; VALID alone defines occupancy.
  logic [KEY_W-1:0]   key_mem  [ENTRIES];
  logic [DATA_W-1:0]  data_mem [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  // S2: packet accepted last cycle, waiting for the controller's decision.
  logic               s2_v;
  logic               s2_mf;
  logic               s2_hit;
  logic [KEY_W-1:0]   s2_key;
  logic [DATA_W-1:0]  s2_data;

  // Output register.
  logic               out_v;
  logic               out_pair;
  logic [KEY_W-1:0]   out_key;
  logic [DATA_W-1:0]  out_data_s;
  logic [DATA_W-1:0]  out_data_i;
  logic               ovf_q;

  logic [ENTRIES-1:0] fire;
  logic               any_hit;
  logic               full;
  logic               out_busy;
  logic               in_rdy;
  logic               xfer;
  logic               do_write;
  logic               do_pair;
  logic               do_bypass;

  // Associative compare of the incoming key against every occupied entry.
  always_comb begin
    fire = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      fire[i] = valid_q[i] & (key_mem[i] == IN_KEY) & IN_V & IN_MF;
    end
  end

  assign any_hit  = |fire;
  assign full     = &valid_q;
  // Output slot counts as free if it is being acked this cycle.
  assign out_busy = out_v & ~OUT_ACK;

  // Accepting only with S2 empty and the output slot free guarantees that the
  // S2 result always has somewhere to go one cycle later, so S2 never stalls.
  // When full, only a new-key match packet has nowhere to go and must wait.
  assign in_rdy = ~s2_v & ~out_busy & (~IN_MF | ~full | any_hit);
  assign xfer   = IN_V & in_rdy;

  // Controller strobes only mean something while S2 holds a packet of the
  // matching kind; idle DEL=1 and stray WR_E are ignored here.
  assign do_write  = s2_v & s2_mf & ~s2_hit & WR_E;
  assign do_pair   = s2_v & s2_mf & s2_hit & DEL;
  assign do_bypass = s2_v & ~s2_mf;

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      valid_q    <= '0;
      s2_v       <= 1'b0;
      s2_mf      <= 1'b0;
      s2_hit     <= 1'b0;
      s2_key     <= '0;
      s2_data    <= '0;
      out_v      <= 1'b0;
      out_pair   <= 1'b0;
      out_key    <= '0;
      out_data_s <= '0;
      out_data_i <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s2_v <= xfer;
      if (xfer) begin
        s2_mf   <= IN_MF;
        s2_hit  <= any_hit;
        s2_key  <= IN_KEY;
        s2_data <= IN_DATA;
      end

      if (do_write) begin
        valid_q[ADDR] <= 1'b1;
        if (valid_q[ADDR]) begin
          ovf_q <= 1'b1;
        end
      end else if (do_pair) begin
        valid_q[ADDR] <= 1'b0;
      end

      // A load can never coincide with a pending output: in_rdy kept the
      // slot free when this packet was accepted.
      if (do_pair || do_bypass) begin
        out_v      <= 1'b1;
        out_pair   <= do_pair;
        out_key    <= s2_key;
        out_data_s <= do_pair ? data_mem[ADDR] : '0;
        out_data_i <= s2_data;
      end else if (out_v && OUT_ACK) begin
        out_v <= 1'b0;
      end
    end
  end

  // Entry payload write; s2_v is held low by reset so no write occurs under MR.
  always_ff @(posedge CP) begin
    if (do_write) begin
      key_mem[ADDR]  <= s2_key;
      data_mem[ADDR] <= s2_data;
    end
  end

  assign IN_RDY     = in_rdy;
  assign FIRE       = fire;
  assign VALID      = valid_q;
  assign MF         = xfer & IN_MF;
  assign OUT_V      = out_v;
  assign OUT_PAIR   = out_pair;
  assign OUT_KEY    = out_key;
  assign OUT_DATA_S = out_data_s;
  assign OUT_DATA_I = out_data_i;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_mm_entry_store.sv
// tb/tb_mm_entry_store.sv - scoreboard bench for mm_entry_store with controller and entry-table model
module tb_mm_entry_store;

  localparam int ENTRIES = 64;
  localparam int ADDR_W  = 6;
  localparam int KEY_W   = 16;
  localparam int DATA_W  = 16;

  logic               CP = 1'b0;
  logic               MR = 1'b1;
  logic               IN_V = 1'b0;
  logic               IN_RDY;
  logic               IN_MF = 1'b0;
  logic [KEY_W-1:0]   IN_KEY = '0;
  logic [DATA_W-1:0]  IN_DATA = '0;
  logic [ENTRIES-1:0] FIRE;
  logic [ENTRIES-1:0] VALID;
  logic               MF;
  logic               WR_E = 1'b0;
  logic               DEL = 1'b1;
  logic [ADDR_W-1:0]  ADDR = '0;
  logic               OUT_V;
  logic               OUT_ACK = 1'b0;
  logic               OUT_PAIR;
  logic [KEY_W-1:0]   OUT_KEY;
  logic [DATA_W-1:0]  OUT_DATA_S;
  logic [DATA_W-1:0]  OUT_DATA_I;
  logic               OVF;

  mm_entry_store #(
    .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .KEY_W(KEY_W), .DATA_W(DATA_W)
  ) dut (
    .CP(CP), .MR(MR), .IN_V(IN_V), .IN_RDY(IN_RDY), .IN_MF(IN_MF),
    .IN_KEY(IN_KEY), .IN_DATA(IN_DATA), .FIRE(FIRE), .VALID(VALID), .MF(MF),
    .WR_E(WR_E), .DEL(DEL), .ADDR(ADDR), .OUT_V(OUT_V), .OUT_ACK(OUT_ACK),
    .OUT_PAIR(OUT_PAIR), .OUT_KEY(OUT_KEY), .OUT_DATA_S(OUT_DATA_S),
    .OUT_DATA_I(OUT_DATA_I), .OVF(OVF)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic        pair;
    logic [15:0] key;
    logic [15:0] ds;
    logic [15:0] di;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_mode = 2;  // 0 random, 1 hold low, 2 hold high

  // Reference table: what the entry array should hold, independent of timing.
  bit          m_valid [ENTRIES];
  logic [15:0] m_key   [ENTRIES];
  logic [15:0] m_data  [ENTRIES];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic logic [63:0] model_valid();
    logic [63:0] v = '0;
    for (int i = 0; i < ENTRIES; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic logic [63:0] model_hits(input logic [15:0] key);
    logic [63:0] v = '0;
    for (int i = 0; i < ENTRIES; i++) v[i] = m_valid[i] && (m_key[i] == key);
    return v;
  endfunction

  function automatic int model_hit(input logic [15:0] key);
    for (int i = 0; i < ENTRIES; i++) if (m_valid[i] && m_key[i] == key) return i;
    return -1;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  task automatic idle_strobes();
    WR_E = 1'($urandom);
    DEL  = 1'b1;
    ADDR = 6'($urandom);
  endtask

  // Output acknowledge driver.
  always @(posedge CP) begin
    #1;
    case (ack_mode)
      0:       OUT_ACK = ($urandom % 4) != 0;
      1:       OUT_ACK = 1'b0;
      default: OUT_ACK = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer, and checks that a
  // stalled output holds its value.
  bit   hold_v = 0;
  exp_t hold;
  always @(negedge CP) begin
    if (MR) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("hold_out_v", OUT_V, 1'b1);
        check("hold_stable", {OUT_PAIR, OUT_KEY, OUT_DATA_S, OUT_DATA_I},
              {hold.pair, hold.key, hold.ds, hold.di});
      end
      if (OUT_V && OUT_ACK) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got key %h with empty scoreboard at %0t", OUT_KEY, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pair", OUT_PAIR, e.pair);
          check("out_key", OUT_KEY, e.key);
          check("out_data_s", OUT_DATA_S, e.ds);
          check("out_data_i", OUT_DATA_I, e.di);
        end
        hold_v = 0;
      end else if (OUT_V) begin
        hold_v = 1;
        hold   = '{OUT_PAIR, OUT_KEY, OUT_DATA_S, OUT_DATA_I};
      end else begin
        hold_v = 0;
      end
    end
  end

  // One packet through the store, with the controller modelled alongside:
  // lowest hit index is fired, otherwise lowest free entry is written.
  task automatic send(input bit mf, input logic [15:0] key, input logic [15:0] data);
    int  hit;
    int  fr;
    int  n;
    bit  done;
    bit  outp;
    @(posedge CP); #1;
    IN_V = 1'b1; IN_MF = mf; IN_KEY = key; IN_DATA = data;
    done = 0; n = 0;
    while (!done && n < 100) begin
      @(negedge CP);
      if (IN_RDY) done = 1; else n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_timeout: key %h never accepted, expected acceptance", key);
      @(posedge CP); #1;
      IN_V = 1'b0;
      return;
    end
    check("valid_pre", VALID, model_valid());
    check("fire", FIRE, mf ? model_hits(key) : 64'd0);
    check("mf_out", MF, mf);
    @(posedge CP); #1;
    IN_V = 1'b0;
    outp = 1;
    hit  = model_hit(key);
    if (!mf) begin
      exp_q.push_back('{1'b0, key, 16'h0, data});
      idle_strobes();
    end else if (hit >= 0) begin
      exp_q.push_back('{1'b1, key, m_data[hit], data});
      m_valid[hit] = 0;
      WR_E = 1'b0; DEL = 1'b1; ADDR = 6'(hit);
    end else begin
      fr   = model_free();
      outp = 0;
      if (fr < 0) begin
        checks++;
        errors++;
        $display("FAIL accepted_when_full: key %h accepted, expected IN_RDY=0", key);
        idle_strobes();
      end else begin
        m_valid[fr] = 1; m_key[fr] = key; m_data[fr] = data;
        WR_E = 1'b1; DEL = 1'b0; ADDR = 6'(fr);
      end
    end
    @(negedge CP);
    check("t1_out_v", OUT_V, 1'b0);
    check("t1_in_rdy", IN_RDY, 1'b0);
    @(posedge CP); #1;
    idle_strobes();
    @(negedge CP);
    check("t2_out_v", OUT_V, outp);
    check("ovf", OVF, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CP);
    MR = 1'b1; IN_V = 1'b0; IN_MF = 1'b0;
    idle_strobes();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    exp_q.delete();
    #1;
    check("rst_valid", VALID, 64'd0);
    check("rst_out_v", OUT_V, 1'b0);
    check("rst_ovf", OVF, 1'b0);
    @(negedge CP);
    MR = 1'b0;
    #1;
    check("rst_in_rdy", IN_RDY, 1'b1);
  endtask

  initial begin
    logic [48:0] snap;
    int          hidx;
    int          n;

    // 1. reset, idle DEL=1 with random addresses clears nothing
    do_reset();
    repeat (4) begin
      @(posedge CP); #1; idle_strobes();
    end
    @(negedge CP);
    check("idle_valid", VALID, 64'd0);

    // 2. write then match
    send(1'b1, 16'h0012, 16'h0005);
    check("w_valid0", VALID[0], 1'b1);
    send(1'b1, 16'h0012, 16'h0007);
    check("m_valid0", VALID[0], 1'b0);

    // 3. bypass
    send(1'b0, 16'h0003, 16'h00AA);
    check("byp_valid", VALID, model_valid());

    // 4. full table
    for (int i = 0; i < ENTRIES; i++) send(1'b1, 16'h0100 + 16'(i), 16'(i * 3));
    check("full_valid", VALID, {64{1'b1}});
    @(posedge CP); #1;
    IN_V = 1'b1; IN_MF = 1'b1; IN_KEY = 16'h0999; IN_DATA = 16'h1234;
    repeat (5) begin
      @(negedge CP);
      check("full_in_rdy", IN_RDY, 1'b0);
      check("full_mf", MF, 1'b0);
      check("full_fire", FIRE, 64'd0);
    end
    @(posedge CP); #1;
    IN_V = 1'b0;
    send(1'b1, 16'h0100 + 16'd37, 16'hBEEF);
    check("full_valid37", VALID[37], 1'b0);
    send(1'b1, 16'h0999, 16'h1234);
    check("refill_valid", VALID, {64{1'b1}});
    send(1'b1, 16'h0999, 16'h4321);
    check("refill_hit37", VALID[37], 1'b0);

    // 5. output backpressure
    ack_mode = 1;
    send(1'b0, 16'h0077, 16'h005A);
    snap = {OUT_PAIR, OUT_KEY, OUT_DATA_S, OUT_DATA_I};
    IN_MF = 1'b0;
    repeat (5) begin
      @(negedge CP);
      check("bp_out_v", OUT_V, 1'b1);
      check("bp_stable", {OUT_PAIR, OUT_KEY, OUT_DATA_S, OUT_DATA_I}, snap);
      check("bp_in_rdy", IN_RDY, 1'b0);
    end
    ack_mode = 2;
    @(negedge CP);
    @(negedge CP);
    check("bp_out_v_after", OUT_V, 1'b0);
    check("bp_in_rdy_after", IN_RDY, 1'b1);

    // 6. reset while a hit sits in S2
    do_reset();
    send(1'b1, 16'h0055, 16'h1111);
    hidx = model_hit(16'h0055);
    @(posedge CP); #1;
    IN_V = 1'b1; IN_MF = 1'b1; IN_KEY = 16'h0055; IN_DATA = 16'h2222;
    @(negedge CP);
    check("mr_in_rdy", IN_RDY, 1'b1);
    check("mr_fire", FIRE, model_hits(16'h0055));
    @(posedge CP); #1;
    IN_V = 1'b0; WR_E = 1'b0; DEL = 1'b1; ADDR = 6'(hidx);
    MR = 1'b1;
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    #1;
    check("mr_valid_now", VALID, 64'd0);
    check("mr_out_v_now", OUT_V, 1'b0);
    @(negedge CP);
    MR = 1'b0;
    @(posedge CP); #1; idle_strobes();
    @(negedge CP);
    check("mr_out_v_later", OUT_V, 1'b0);
    check("mr_valid_later", VALID, 64'd0);

    // randomized traffic against the reference table
    ack_mode = 0;
    for (int t = 0; t < 300; t++) begin
      if (($urandom % 100) < 70)
        send(1'b1, 16'h0020 + 16'($urandom % 12), 16'($urandom));
      else
        send(1'b0, 16'($urandom), 16'($urandom));
      repeat ($urandom % 3) @(posedge CP);
    end

    ack_mode = 2;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge CP);
      n++;
    end
    check("drain", exp_q.size(), 0);
    check("final_valid", VALID, model_valid());
    check("final_ovf", OVF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
